// File: rtl/cues_sw_pkg.sv
// Shared definitions for the CUES token switch: default token width, token
// field layout and the destination-width rule used by the switch ports.
package cues_sw_pkg;

    localparam int DATA_W_DEF  = 62;

    // Token layout, LSB first: {uni_opr, opr[31:0], gen[11:0], node[15:0], lr}
    localparam int LR_OFF      = 0;
    localparam int LR_W        = 1;
    localparam int NODE_OFF    = 1;
    localparam int NODE_W      = 16;
    localparam int GEN_OFF     = 17;
    localparam int GEN_W       = 12;
    localparam int OPR_OFF     = 29;
    localparam int OPR_W       = 32;
    localparam int UNI_OPR_OFF = 61;
    localparam int UNI_OPR_W   = 1;

    typedef struct packed {
        logic        uni_opr;
        logic [31:0] opr;
        logic [11:0] gen;
        logic [15:0] node;
        logic        lr;
    } cues_token_t;

    // Destination field width: a mask needs one bit per channel, an index
    // needs enough bits to name every channel.
    function automatic int dst_w(input int mcast, input int n_out);
        if (mcast != 0) begin
            return n_out;
        end else begin
            return $clog2(n_out);
        end
    endfunction

endpackage

// File: rtl/token_fifo.sv
// Per-channel token FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module token_fifo
    import cues_sw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    // Status flags, guarded push/pop and the head token straight from storage
    always_comb begin
        empty  = (r_wr_ptr == r_rd_ptr);
        full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_push = push & ~full;
        w_pop  = pop & ~empty;
        dout   = r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO and discards its contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Token storage; needs no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/token_sw_n.sv
// N-way CUES token switch: decodes the destination into a push mask, accepts
// a token only when every targeted FIFO has room (multicast is all-or-none),
// and counts tokens that name no valid channel.
module token_sw_n
    import cues_sw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_OUT  = 2,
    parameter int DEPTH  = 4,
    parameter int MCAST  = 0,
    parameter int DST_W  = dst_w(MCAST, N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send_i,
    output logic                    ack_o,
    input  logic [DATA_W-1:0]       data_i,
    input  logic [DST_W-1:0]        dst_i,
    output logic [N_OUT-1:0]        send_o,
    input  logic [N_OUT-1:0]        ack_i,
    output logic [N_OUT*DATA_W-1:0] data_o,
    output logic                    drop_o,
    output logic [15:0]             drop_cnt_o
);

    logic             r_run;
    logic             r_drop;
    logic [15:0]      r_drop_cnt;
    logic [N_OUT-1:0] w_sel;
    logic [N_OUT-1:0] w_full;
    logic [N_OUT-1:0] w_empty;
    logic [N_OUT-1:0] w_push;
    logic [N_OUT-1:0] w_pop;
    logic             w_xfer;
    logic             w_drop;

    generate
        if (MCAST != 0) begin : g_mask
            // The destination already is the channel mask
            always_comb w_sel = dst_i;
        end else begin : g_index
            // One-hot decode of the index; out-of-range indices select nothing
            always_comb begin
                w_sel = {N_OUT{1'b0}};
                for (int k = 0; k < N_OUT; k++) begin
                    if (int'(dst_i) == k) begin
                        w_sel[k] = 1'b1;
                    end else begin
                        w_sel[k] = 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Accept decision uses only FIFO state and dst_i, never the consumer acks
    always_comb begin
        ack_o  = r_run & ~(|(w_sel & w_full));
        w_xfer = send_i & ack_o;
        w_push = w_xfer ? w_sel : {N_OUT{1'b0}};
        w_drop = w_xfer & ~(|w_sel);
        w_pop  = ack_i & ~w_empty;
        send_o = ~w_empty;
    end

    // Run flag holds off acceptance until the first edge after reset; drop pulse and saturating count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_drop     <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            r_run  <= 1'b1;
            r_drop <= w_drop;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'h0001;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign drop_o     = r_drop;
    assign drop_cnt_o = r_drop_cnt;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_ch
            token_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push[k]),
                .din   (data_i),
                .pop   (w_pop[k]),
                .dout  (data_o[k*DATA_W +: DATA_W]),
                .empty (w_empty[k]),
                .full  (w_full[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_token_sw_n.sv
// Directed and randomised checks of token_sw_n in three configurations:
// a: N_OUT=2 index mode, b: N_OUT=4 multicast mode, c: N_OUT=3 index mode.
module tb_token_sw_n;
    import cues_sw_pkg::*;

    localparam int DW = 62;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic            a_send, a_ack, a_drop;
    logic [DW-1:0]   a_din;
    logic [0:0]      a_dst;
    logic [1:0]      a_so, a_ai;
    logic [2*DW-1:0] a_dout;
    logic [15:0]     a_dcnt;

    logic            b_send, b_ack, b_drop;
    logic [DW-1:0]   b_din;
    logic [3:0]      b_dst, b_so, b_ai;
    logic [4*DW-1:0] b_dout;
    logic [15:0]     b_dcnt;

    logic            c_send, c_ack, c_drop;
    logic [DW-1:0]   c_din;
    logic [1:0]      c_dst;
    logic [2:0]      c_so, c_ai;
    logic [3*DW-1:0] c_dout;
    logic [15:0]     c_dcnt;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    token_sw_n #(.DATA_W(DW), .N_OUT(2), .DEPTH(4), .MCAST(0)) u_a (
        .clk(clk), .rst(rst), .send_i(a_send), .ack_o(a_ack), .data_i(a_din), .dst_i(a_dst),
        .send_o(a_so), .ack_i(a_ai), .data_o(a_dout), .drop_o(a_drop), .drop_cnt_o(a_dcnt));

    token_sw_n #(.DATA_W(DW), .N_OUT(4), .DEPTH(4), .MCAST(1)) u_b (
        .clk(clk), .rst(rst), .send_i(b_send), .ack_o(b_ack), .data_i(b_din), .dst_i(b_dst),
        .send_o(b_so), .ack_i(b_ai), .data_o(b_dout), .drop_o(b_drop), .drop_cnt_o(b_dcnt));

    token_sw_n #(.DATA_W(DW), .N_OUT(3), .DEPTH(4), .MCAST(0)) u_c (
        .clk(clk), .rst(rst), .send_i(c_send), .ack_o(c_ack), .data_i(c_din), .dst_i(c_dst),
        .send_o(c_so), .ack_i(c_ai), .data_o(c_dout), .drop_o(c_drop), .drop_cnt_o(c_dcnt));

    function automatic logic [DW-1:0] mk_tok(input logic [31:0] opr, input logic [15:0] node);
        cues_token_t t;
        t.uni_opr = 1'b0;
        t.opr     = opr;
        t.gen     = 12'h5A5;
        t.node    = node;
        t.lr      = 1'b1;
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        a_send = 1'b1; a_din = mk_tok(32'h0000_0001, 16'h0001); a_dst = 1'b0;   a_ai = 2'b00;
        b_send = 1'b1; b_din = mk_tok(32'h0000_0002, 16'h0002); b_dst = 4'b0001; b_ai = 4'b0000;
        c_send = 1'b1; c_din = mk_tok(32'h0000_0003, 16'h0003); c_dst = 2'd3;   c_ai = 3'b000;
        repeat (3) tick;
        n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack_a: got %b want 0", a_ack); end
        n_cmp++; if (a_so !== 2'b00) begin n_err++; $display("FAIL rst_send_a: got %b want 00", a_so); end
        n_cmp++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack_b: got %b want 0", b_ack); end
        n_cmp++; if (b_so !== 4'b0000) begin n_err++; $display("FAIL rst_send_b: got %b want 0000", b_so); end
        n_cmp++; if (c_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack_c: got %b want 0", c_ack); end
        n_cmp++; if (c_drop !== 1'b0) begin n_err++; $display("FAIL rst_drop_c: got %b want 0", c_drop); end
        a_send = 1'b0; b_send = 1'b0; c_send = 1'b0;
        rst = 1'b1;
        tick;
        n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL rel_ack_a: got %b want 1", a_ack); end
        n_cmp++; if (a_dcnt !== 16'h0000) begin n_err++; $display("FAIL rel_cnt_a: got %h want 0000", a_dcnt); end
        n_cmp++; if (b_ack !== 1'b1) begin n_err++; $display("FAIL rel_ack_b: got %b want 1", b_ack); end
        n_cmp++; if (c_ack !== 1'b1) begin n_err++; $display("FAIL rel_ack_c: got %b want 1", c_ack); end
        n_cmp++; if (c_dcnt !== 16'h0000) begin n_err++; $display("FAIL rel_cnt_c: got %h want 0000", c_dcnt); end
    endtask

    task automatic test_route;
        logic [DW-1:0] t;
        t = mk_tok(32'h1234_5678, 16'h00A1);
        a_din = t; a_dst = 1'b1; a_send = 1'b1; a_ai = 2'b00;
        #1;
        n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL route_ack: got %b want 1", a_ack); end
        tick;
        a_send = 1'b0;
        n_cmp++; if (a_so !== 2'b10) begin n_err++; $display("FAIL route_send: got %b want 10", a_so); end
        n_cmp++; if (a_dout[DW +: DW] !== t) begin n_err++; $display("FAIL route_data: got %h want %h", a_dout[DW +: DW], t); end
        tick;
        n_cmp++; if (a_dout[DW +: DW] !== t) begin n_err++; $display("FAIL route_hold: got %h want %h", a_dout[DW +: DW], t); end
        a_ai = 2'b10;
        tick;
        a_ai = 2'b00;
        n_cmp++; if (a_so !== 2'b00) begin n_err++; $display("FAIL route_pop: got %b want 00", a_so); end
    endtask

    task automatic test_fill;
        logic [DW-1:0] t;
        a_ai = 2'b00; a_dst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_din = mk_tok(32'hF000_0000 + 32'(i), 16'(i)); a_send = 1'b1;
            #1;
            n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack_%0d: got %b want 1", i, a_ack); end
            tick;
        end
        a_din = mk_tok(32'hF000_0004, 16'd4);
        #1;
        n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL full_ack: got %b want 0", a_ack); end
        n_cmp++; if (a_so !== 2'b01) begin n_err++; $display("FAIL full_send: got %b want 01", a_so); end
        tick;
        t = mk_tok(32'hF000_0000, 16'd0);
        n_cmp++; if (a_dout[0 +: DW] !== t) begin n_err++; $display("FAIL full_head: got %h want %h", a_dout[0 +: DW], t); end
        a_ai = 2'b01;
        #1;
        n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL pop_no_path: got %b want 0", a_ack); end
        tick;
        a_ai = 2'b00;
        #1;
        n_cmp++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL pop_then_ack: got %b want 1", a_ack); end
        tick;
        a_send = 1'b0;
        a_ai = 2'b01;
        for (int i = 1; i < 5; i++) begin
            t = mk_tok(32'hF000_0000 + 32'(i), 16'(i));
            n_cmp++; if (a_dout[0 +: DW] !== t || a_so[0] !== 1'b1) begin
                n_err++; $display("FAIL order_%0d: got %h want %h", i, a_dout[0 +: DW], t);
            end
            tick;
        end
        a_ai = 2'b00;
        n_cmp++; if (a_so !== 2'b00) begin n_err++; $display("FAIL fill_drained: got %b want 00", a_so); end
    endtask

    task automatic test_mcast;
        logic [DW-1:0] t;
        t = mk_tok(32'hAAAA_5555, 16'h000A);
        b_ai = 4'b0000; b_dst = 4'b1000; b_send = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_din = mk_tok(32'hC000_0000 + 32'(i), 16'h0003);
            tick;
        end
        b_din = t; b_dst = 4'b1010;
        #1;
        n_cmp++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL mc_blocked: got %b want 0", b_ack); end
        tick;
        n_cmp++; if (b_so !== 4'b1000) begin n_err++; $display("FAIL mc_atomic: got %b want 1000", b_so); end
        b_ai = 4'b1000;
        tick;
        b_ai = 4'b0000;
        #1;
        n_cmp++; if (b_ack !== 1'b1) begin n_err++; $display("FAIL mc_freed: got %b want 1", b_ack); end
        tick;
        b_send = 1'b0;
        n_cmp++; if (b_so !== 4'b1010) begin n_err++; $display("FAIL mc_written: got %b want 1010", b_so); end
        n_cmp++; if (b_dout[DW +: DW] !== t) begin n_err++; $display("FAIL mc_data1: got %h want %h", b_dout[DW +: DW], t); end
        b_ai = 4'b1000;
        repeat (3) tick;
        b_ai = 4'b0000;
        n_cmp++; if (b_dout[3*DW +: DW] !== t) begin n_err++; $display("FAIL mc_data3: got %h want %h", b_dout[3*DW +: DW], t); end
        b_ai = 4'b1010;
        tick;
        b_ai = 4'b0000;
        n_cmp++; if (b_so !== 4'b0000) begin n_err++; $display("FAIL mc_drained: got %b want 0000", b_so); end
        b_dst = 4'b0000; b_send = 1'b1;
        #1;
        n_cmp++; if (b_ack !== 1'b1) begin n_err++; $display("FAIL mc_zero_ack: got %b want 1", b_ack); end
        tick;
        b_send = 1'b0;
        n_cmp++; if (b_drop !== 1'b1 || b_dcnt !== 16'h0001) begin
            n_err++; $display("FAIL mc_zero_drop: got %b/%h want 1/0001", b_drop, b_dcnt);
        end
        tick;
        n_cmp++; if (b_drop !== 1'b0) begin n_err++; $display("FAIL mc_drop_pulse: got %b want 0", b_drop); end
    endtask

    task automatic test_drop_sat;
        logic [DW-1:0] t;
        t = mk_tok(32'h0BAD_F00D, 16'h0C02);
        c_ai = 3'b111; c_dst = 2'd3; c_din = mk_tok(32'hDEAD_0000, 16'h0C00); c_send = 1'b1;
        #1;
        n_cmp++; if (c_ack !== 1'b1) begin n_err++; $display("FAIL drop_ack: got %b want 1", c_ack); end
        tick;
        c_send = 1'b0;
        n_cmp++; if (c_drop !== 1'b1 || c_dcnt !== 16'h0001 || c_so !== 3'b000) begin
            n_err++; $display("FAIL drop_first: got %b/%h/%b want 1/0001/000", c_drop, c_dcnt, c_so);
        end
        tick;
        n_cmp++; if (c_drop !== 1'b0 || c_dcnt !== 16'h0001) begin
            n_err++; $display("FAIL drop_pulse: got %b/%h want 0/0001", c_drop, c_dcnt);
        end
        c_ai = 3'b000; c_dst = 2'd2; c_din = t; c_send = 1'b1;
        tick;
        c_send = 1'b0;
        n_cmp++; if (c_so !== 3'b100 || c_dout[2*DW +: DW] !== t || c_drop !== 1'b0) begin
            n_err++; $display("FAIL c_route: got %b/%h want 100/%h", c_so, c_dout[2*DW +: DW], t);
        end
        c_ai = 3'b100;
        tick;
        c_ai = 3'b000; c_dst = 2'd3; c_send = 1'b1;
        repeat (65533) tick;
        n_cmp++; if (c_dcnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h want fffe", c_dcnt); end
        tick;
        n_cmp++; if (c_dcnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff: got %h want ffff", c_dcnt); end
        repeat (2) tick;
        n_cmp++; if (c_dcnt !== 16'hFFFF || c_drop !== 1'b1) begin
            n_err++; $display("FAIL sat_stick: got %h/%b want ffff/1", c_dcnt, c_drop);
        end
        c_send = 1'b0;
        tick;
        n_cmp++; if (c_drop !== 1'b0) begin n_err++; $display("FAIL sat_idle: got %b want 0", c_drop); end
    endtask

    task automatic test_random;
        int   accepted = 0;
        int   cycles   = 0;
        int   id       = 0;
        logic pending  = 1'b0;
        logic exp_ack;
        logic [1:0] ai;
        q0.delete(); q1.delete();
        a_send = 1'b0; a_ai = 2'b00;
        while (accepted < 10000 && cycles < 60000) begin
            n_cmp++; if (a_so !== {q1.size() != 0, q0.size() != 0}) begin
                n_err++; $display("FAIL rnd_send c%0d: got %b want %b", cycles, a_so, {q1.size() != 0, q0.size() != 0});
            end
            if (q0.size() != 0) begin
                n_cmp++; if (a_dout[0 +: DW] !== q0[0]) begin
                    n_err++; $display("FAIL rnd_data0 c%0d: got %h want %h", cycles, a_dout[0 +: DW], q0[0]);
                end
            end
            if (q1.size() != 0) begin
                n_cmp++; if (a_dout[DW +: DW] !== q1[0]) begin
                    n_err++; $display("FAIL rnd_data1 c%0d: got %h want %h", cycles, a_dout[DW +: DW], q1[0]);
                end
            end
            if (!pending && $urandom_range(0, 3) != 0) begin
                a_din   = {$urandom(), 30'(id)};
                a_dst   = 1'($urandom_range(0, 1));
                pending = 1'b1;
                id++;
            end
            a_send = pending;
            ai     = 2'($urandom_range(0, 3));
            a_ai   = ai;
            #1;
            exp_ack = (a_dst == 1'b0) ? (q0.size() < 4) : (q1.size() < 4);
            n_cmp++; if (a_ack !== exp_ack) begin
                n_err++; $display("FAIL rnd_ack c%0d: got %b want %b", cycles, a_ack, exp_ack);
            end
            if (ai[0] && q0.size() != 0) void'(q0.pop_front());
            if (ai[1] && q1.size() != 0) void'(q1.pop_front());
            if (pending && exp_ack) begin
                if (a_dst == 1'b0) q0.push_back(a_din);
                else               q1.push_back(a_din);
                pending = 1'b0;
                accepted++;
            end
            tick;
            cycles++;
        end
        a_send = 1'b0;
        n_cmp++; if (accepted < 10000) begin n_err++; $display("FAIL rnd_budget: got %0d want 10000", accepted); end
        a_ai = 2'b11;
        for (int i = 0; i < 5; i++) begin
            if (q0.size() != 0) begin
                n_cmp++; if (a_dout[0 +: DW] !== q0[0]) begin
                    n_err++; $display("FAIL drain0: got %h want %h", a_dout[0 +: DW], q0[0]);
                end
                void'(q0.pop_front());
            end
            if (q1.size() != 0) begin
                n_cmp++; if (a_dout[DW +: DW] !== q1[0]) begin
                    n_err++; $display("FAIL drain1: got %h want %h", a_dout[DW +: DW], q1[0]);
                end
                void'(q1.pop_front());
            end
            tick;
        end
        a_ai = 2'b00;
        n_cmp++; if (a_so !== 2'b00) begin n_err++; $display("FAIL rnd_empty: got %b want 00", a_so); end
    endtask

    task automatic test_mid_reset;
        a_din = mk_tok(32'h7777_0000, 16'h0077); a_dst = 1'b0; a_send = 1'b1; a_ai = 2'b00;
        tick;
        a_send = 1'b0;
        n_cmp++; if (a_so !== 2'b01) begin n_err++; $display("FAIL mid_loaded: got %b want 01", a_so); end
        rst = 1'b0;
        #1;
        n_cmp++; if (a_so !== 2'b00 || a_ack !== 1'b0) begin
            n_err++; $display("FAIL mid_rst: got %b/%b want 00/0", a_so, a_ack);
        end
        n_cmp++; if (c_dcnt !== 16'h0000) begin n_err++; $display("FAIL mid_cnt: got %h want 0000", c_dcnt); end
        tick;
        rst = 1'b1;
        tick;
        n_cmp++; if (a_so !== 2'b00 || a_ack !== 1'b1) begin
            n_err++; $display("FAIL mid_release: got %b/%b want 00/1", a_so, a_ack);
        end
    endtask

    initial begin
        test_reset;
        test_route;
        test_fill;
        test_mcast;
        fork
            test_drop_sat;
            test_random;
        join
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
